imem_boot_loader: RTL and testbench

- Host-side writer for the instruction-memory load port (load_mem_en / load_mem_addr / load_mem_data) of cpu_top.
- Receives a byte stream over a valid/ready interface and assembles 32-bit instruction words, most significant byte first.
- Issues one single-cycle memory write per word, checks a trailing XOR checksum byte, then releases the CPU from reset.
- Replaces bench-driven program loading in hardware builds.

---
 rtl/imem_boot_loader_if.sv | 22 ++
 rtl/imem_boot_loader.sv | 106 ++++++++++
 tb/tb_imem_boot_loader.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory load port of the boot loader.
// The host/bench side takes the master modport, the loader takes the slave modport.
interface imem_boot_loader_if #(
    parameter int ADDR_W = 5
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              load_mem_en;
    logic [ADDR_W-1:0] load_mem_addr;
    logic [31:0]       load_mem_data;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, load_mem_en, load_mem_addr, load_mem_data
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, load_mem_en, load_mem_addr, load_mem_data
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: assembles MSB-first words from a byte stream, writes them to the
// CPU instruction memory, verifies a trailing XOR checksum and releases the CPU.
module imem_boot_loader #(
    parameter int WORDS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    imem_boot_loader_if.slave bus,
    output logic              cpu_rst_n,
    output logic              boot_done,
    output logic              boot_err
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(WORDS - 1);

    state_t          state;
    logic [1:0]      byte_cnt;
    logic [ADDR_W:0] word_cnt;
    logic [7:0]      csum;
    logic [23:0]     shreg;
    logic            xfer;

    assign xfer = bus.byte_valid && bus.byte_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            byte_cnt          <= '0;
            word_cnt          <= '0;
            csum              <= '0;
            shreg             <= '0;
            bus.byte_ready    <= 1'b0;
            bus.load_mem_en   <= 1'b0;
            bus.load_mem_addr <= '0;
            bus.load_mem_data <= '0;
            cpu_rst_n         <= 1'b0;
            boot_done         <= 1'b0;
            boot_err          <= 1'b0;
        end else begin
            bus.load_mem_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state          <= S_RECV;
                        byte_cnt       <= '0;
                        word_cnt       <= '0;
                        csum           <= '0;
                        bus.byte_ready <= 1'b1;
                        cpu_rst_n      <= 1'b0;
                        boot_done      <= 1'b0;
                        boot_err       <= 1'b0;
                    end
                end
                S_RECV: begin
                    if (xfer) begin
                        shreg <= {shreg[15:0], bus.byte_data};
                        csum  <= csum ^ bus.byte_data;
                        if (byte_cnt == 2'd3) begin
                            // Strobe is set on the accepting edge so it is high in the WRITE cycle.
                            byte_cnt          <= '0;
                            state             <= S_WRITE;
                            bus.byte_ready    <= 1'b0;
                            bus.load_mem_en   <= 1'b1;
                            bus.load_mem_addr <= word_cnt[ADDR_W-1:0];
                            bus.load_mem_data <= {shreg, bus.byte_data};
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                S_WRITE: begin
                    word_cnt       <= word_cnt + (ADDR_W+1)'(1);
                    bus.byte_ready <= 1'b1;
                    state          <= (word_cnt == LAST_WORD) ? S_CHECK : S_RECV;
                end
                S_CHECK: begin
                    if (xfer) begin
                        bus.byte_ready <= 1'b0;
                        if (bus.byte_data == csum) begin
                            state     <= S_DONE;
                            cpu_rst_n <= 1'b1;
                            boot_done <= 1'b1;
                        end else begin
                            state    <= S_ERROR;
                            boot_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state          <= S_IDLE;
                    bus.byte_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: expected writes are queued as bytes are
// driven and popped by a monitor whenever the write strobe is seen.
module tb_imem_boot_loader;
    localparam int WORDS  = 32;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic cpu_rst_n, boot_done, boot_err;

    wr_t        exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] csum_model;
    bit         rand_gaps = 1'b0;

    imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_boot_loader #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus),
        .cpu_rst_n (cpu_rst_n),
        .boot_done (boot_done),
        .boot_err  (boot_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Every strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (bus.load_mem_en === 1'b1) begin
            n_vec++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL stray_write observed addr=%h data=%h expected no write",
                       bus.load_mem_addr, bus.load_mem_data);
            end
            if (exp_q.size() != 0) begin
                wr_t w;
                w = exp_q.pop_front();
                chk("wr_addr", 32'(bus.load_mem_addr), 32'(w.addr));
                chk("wr_data", bus.load_mem_data, w.data);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        if (rand_gaps) begin
            for (int k = 0; k < 8 && $urandom_range(1) == 0; k++) begin
                bus.byte_valid = 1'b0;
                @(negedge clk);
            end
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (bus.byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        assert (n < 50) else begin
            n_err++;
            $error("FAIL byte_timeout observed=%0d cycles expected<50", n);
        end
        @(posedge clk);
        @(negedge clk);
        csum_model = csum_model ^ b;
    endtask

    task automatic send_word(input int idx);
        logic [31:0] w;
        wr_t e;
        w = 32'h2008_0000 + 32'(idx);
        e.addr = ADDR_W'(idx);
        e.data = w;
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        exp_q.push_back(e);
        send_byte(w[7:0]);
        chk("wr_latency", 32'(bus.load_mem_en), 32'd1);
    endtask

    task automatic load_image(input bit bad, input bit poke);
        csum_model = 8'h00;
        for (int i = 0; i < WORDS; i++) begin
            if (poke && i == 7) begin
                bus.byte_valid = 1'b0;
                @(negedge clk);
                pulse_start();
            end
            send_word(i);
        end
        bus.byte_valid = 1'b0;
        @(negedge clk);
        chk("check_ready", 32'(bus.byte_ready), 32'd1);
        if (poke) begin
            pulse_start();
            chk("check_hold_ready", 32'(bus.byte_ready), 32'd1);
        end
        send_byte(bad ? (csum_model ^ 8'h01) : csum_model);
        bus.byte_valid = 1'b0;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("boot_done", 32'(boot_done), bad ? 32'd0 : 32'd1);
        chk("cpu_rst_n", 32'(cpu_rst_n), bad ? 32'd0 : 32'd1);
        chk("boot_err", 32'(boot_err), bad ? 32'd1 : 32'd0);
        chk("idle_ready", 32'(bus.byte_ready), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
        chk({tag, "_en"}, 32'(bus.load_mem_en), 32'd0);
        chk({tag, "_addr"}, 32'(bus.load_mem_addr), 32'd0);
        chk({tag, "_data"}, bus.load_mem_data, 32'd0);
        chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
        chk({tag, "_done"}, 32'(boot_done), 32'd0);
        chk({tag, "_err"}, 32'(boot_err), 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hA5;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_ready_held_valid", 32'(bus.byte_ready), 32'd0);
        bus.byte_valid = 1'b0;
        pulse_start();
        chk("start_ready", 32'(bus.byte_ready), 32'd1);
        chk("start_cpu_rst_n", 32'(cpu_rst_n), 32'd0);

        load_image(1'b0, 1'b1);

        pulse_start();
        chk("restart_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("restart_done", 32'(boot_done), 32'd0);
        chk("restart_ready", 32'(bus.byte_ready), 32'd1);
        load_image(1'b1, 1'b0);

        pulse_start();
        chk("err_clear", 32'(boot_err), 32'd0);
        rand_gaps = 1'b1;
        load_image(1'b0, 1'b0);
        rand_gaps = 1'b0;

        pulse_start();
        csum_model = 8'h00;
        for (int i = 0; i < 5; i++) send_word(i);
        send_byte(8'h20);
        send_byte(8'h08);
        bus.byte_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_vals("midload_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_queue", 32'(exp_q.size()), 32'd0);
        pulse_start();
        load_image(1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
